// File: rtl/nic8_pkg.sv
// Shared nic8 definitions: sequencer state encoding, instruction register layout
// and the operand encodings agreed with the control decoder.
package nic8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // IR layout: bit7, dest[6:4], bit3, source[2:0]
  typedef struct packed {
    logic       bit7;
    logic [2:0] dest;
    logic       bit3;
    logic [2:0] src;
  } ir_t;

  localparam logic [2:0] DEST_PC = 3'd7;
  localparam logic [2:0] SRC_ROM = 3'd1;

  function automatic logic [2:0] ir_dest(input logic [7:0] ir);
    ir_t f;
    f = ir_t'(ir);
    return f.dest;
  endfunction

  function automatic logic [2:0] ir_src(input logic [7:0] ir);
    ir_t f;
    f = ir_t'(ir);
    return f.src;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its environment (ROM, control decoder,
// run/step switches). The sequencer takes the slave side.
interface fetch_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic [7:0]          romData;
  logic [7:0]          dbus;
  logic                doJumpBar;
  logic                denyFetch;
  logic                run;
  logic                step;
  logic [7:0]          ir;
  logic [PC_WIDTH-1:0] romAddr;
  logic [PC_WIDTH-1:0] pc;
  logic                exec;
  logic                halted;
  logic [7:0]          instrCount;

  modport slave (
    input  romData, dbus, doJumpBar, denyFetch, run, step,
    output ir, romAddr, pc, exec, halted, instrCount
  );

  modport master (
    output romData, dbus, doJumpBar, denyFetch, run, step,
    input  ir, romAddr, pc, exec, halted, instrCount
  );
endinterface

// File: rtl/fetch_sequencer_step_edge.sv
// Registered rising-edge detector for the single-step request.
module step_edge (
  input  logic clk,
  input  logic resetBar,
  input  logic step,
  output logic step_rise
);

  logic step_q;
  logic step_d;

  always_comb begin
    step_d = step;
  end

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_rise = step & ~step_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: owns PC, IR and the FETCH/EXEC phase, applies the
// control decoder's jump/immediate decisions and latches a jump-to-self halt.
module fetch_sequencer
  import nic8_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input logic               clk,
  input logic               resetBar,
  fetch_sequencer_if.slave  bus
);

  state_t              state_q, state_d, cur_state_s, after_exec_s;
  logic                fresh_q;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                halted_q, halted_d;
  logic                exec_q, exec_d;
  logic                step_rise_s;
  logic [PC_WIDTH-1:0] target_s;
  logic [PC_WIDTH-1:0] instr_addr_s;

  step_edge u_step_edge (
    .clk       (clk),
    .resetBar  (resetBar),
    .step      (bus.step),
    .step_rise (step_rise_s)
  );

  // The first cycle out of reset picks FETCH or IDLE from run, without a wasted IDLE cycle.
  always_comb begin
    cur_state_s = state_q;
    if (fresh_q) begin
      cur_state_s = bus.run ? ST_FETCH : ST_IDLE;
    end else begin
      cur_state_s = state_q;
    end
  end

  assign target_s     = PC_WIDTH'(bus.dbus);
  assign instr_addr_s = pc_q - PC_WIDTH'(1);
  assign after_exec_s = bus.run ? ST_FETCH : ST_IDLE;

  always_comb begin
    state_d  = cur_state_s;
    pc_d     = pc_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    case (cur_state_s)
      ST_IDLE: begin
        if (bus.run || step_rise_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ir_d    = bus.romData;
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        cnt_d = cnt_q + 8'd1;
        if (!bus.doJumpBar) begin
          pc_d = target_s;
          // A jump back onto its own opcode can never make progress.
          if (target_s == instr_addr_s) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            state_d = after_exec_s;
          end
        end else if (bus.denyFetch) begin
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = after_exec_s;
        end else begin
          state_d = after_exec_s;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    exec_d = (state_d == ST_EXEC);
  end

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state_q  <= ST_IDLE;
      fresh_q  <= 1'b1;
      pc_q     <= RESET_PC;
      ir_q     <= 8'h00;
      cnt_q    <= 8'h00;
      halted_q <= 1'b0;
      exec_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fresh_q  <= 1'b0;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      exec_q   <= exec_d;
    end
  end

  assign bus.ir         = ir_q;
  assign bus.pc         = pc_q;
  assign bus.romAddr    = pc_q;
  assign bus.exec       = exec_q;
  assign bus.halted     = halted_q;
  assign bus.instrCount = cnt_q;

endmodule
